// File: rtl/pool3_pkg.sv
// Shared types and the lane-wise signed max used by the pool3 max-pooling stage.
package pool3_pkg;

   localparam int DW  = 16;
   localparam int KPF = 4;
   localparam int GRP = 16;

   typedef logic signed [DW-1:0] lane_t;
   typedef lane_t [KPF-1:0]      beat_t;

   function automatic beat_t max4(input beat_t a, input beat_t b);
      beat_t y;
      for (int k = 0; k < KPF; k++)
         y[k] = ($signed(a[k]) > $signed(b[k])) ? a[k] : b[k];
      return y;
   endfunction

endpackage

// File: rtl/vec_max.sv
// Combinational KPF-lane signed maximum of two packed beats.
module vec_max
   import pool3_pkg::*;
(
   input  beat_t a,
   input  beat_t b,
   output beat_t y
);

   assign y = max4(a, b);

endmodule

// File: rtl/pool3_layer.sv
// 2x2 stride-2 max-pooling stage for the conv3 blob stream.
// Optional framing check enabled by defining POOL3_EOP_CHECK_EN.
module pool3_layer
   import pool3_pkg::*;
#(
   parameter int W_IN = 8,
   parameter int H_IN = 8,
   parameter int C_IN = 64,
   parameter int KPF  = 4,
   parameter int DW   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [KPF*DW-1:0] blob_din,
   input  logic              blob_din_en,
   input  logic              blob_din_eop,
   output logic              blob_din_rdy,
   output logic [KPF*DW-1:0] blob_dout,
   output logic              blob_dout_en,
   output logic              blob_dout_eop,
   input  logic              blob_dout_rdy,
   output logic              pool_err
);

   localparam int GRP  = C_IN / KPF;
   localparam int NBUF = (W_IN / 2) * GRP;
   localparam int GW   = (GRP > 1) ? $clog2(GRP) : 1;
   localparam int WW   = $clog2(W_IN);
   localparam int HW   = $clog2(H_IN);
   localparam int IW   = (NBUF > 1) ? $clog2(NBUF) : 1;

   logic [GW-1:0] g_q;
   logic [WW-1:0] w_q;
   logic [HW-1:0] h_q;
   logic [IW-1:0] idx;
   logic          accept, emit, resync;
   logic          g_last, w_last, h_last, last_beat;

   beat_t din_p0, buf_rd_p0, max_p0;
   beat_t pbuf [NBUF];
   beat_t dout_p1;
   logic  vld_p1, eop_p1;

   assign din_p0       = beat_t'(blob_din);
   assign blob_din_rdy = !vld_p1 || blob_dout_rdy;
   assign accept       = blob_din_en && blob_din_rdy;

   assign g_last    = (g_q == GW'(GRP - 1));
   assign w_last    = (w_q == WW'(W_IN - 1));
   assign h_last    = (h_q == HW'(H_IN - 1));
   assign last_beat = g_last && w_last && h_last;

   // Second row, second column of a window closes it and goes straight out
   assign emit = accept && h_q[0] && w_q[0];
   assign idx  = IW'(int'(w_q >> 1) * GRP + int'(g_q));

`ifdef POOL3_EOP_CHECK_EN
   logic err_q;

   assign resync = accept && blob_din_eop && !last_beat;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         err_q <= 1'b0;
      else if (accept && (blob_din_eop != last_beat))
         err_q <= 1'b1;
   end

   assign pool_err = err_q;
`else
   logic unused_eop;

   assign unused_eop = blob_din_eop;
   assign resync     = 1'b0;
   assign pool_err   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         g_q <= '0;
         w_q <= '0;
         h_q <= '0;
      end else if (resync) begin
         g_q <= '0;
         w_q <= '0;
         h_q <= '0;
      end else if (accept) begin
         if (g_last) begin
            g_q <= '0;
            if (w_last) begin
               w_q <= '0;
               h_q <= h_last ? '0 : h_q + HW'(1);
            end else begin
               w_q <= w_q + WW'(1);
            end
         end else begin
            g_q <= g_q + GW'(1);
         end
      end
   end

   // Stage p0: partial-max read and combine
   assign buf_rd_p0 = pbuf[idx];

   vec_max u_vec_max (
      .a (buf_rd_p0),
      .b (din_p0),
      .y (max_p0)
   );

   // Buffer is always written before read within a frame, so it needs no reset
   always_ff @(posedge clk) begin
      if (accept && !emit)
         pbuf[idx] <= (h_q[0] || w_q[0]) ? max_p0 : din_p0;
   end

   // Stage p1: output register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1  <= 1'b0;
         eop_p1  <= 1'b0;
         dout_p1 <= '0;
      end else if (emit) begin
         vld_p1  <= 1'b1;
         eop_p1  <= last_beat;
         dout_p1 <= max_p0;
      end else if (blob_dout_rdy) begin
         vld_p1  <= 1'b0;
         eop_p1  <= 1'b0;
      end
   end

   assign blob_dout     = dout_p1;
   assign blob_dout_en  = vld_p1;
   assign blob_dout_eop = eop_p1;

endmodule

// File: tb/tb_pool3_layer.sv
// Self-checking bench for pool3_layer against a window-based max-pool reference.
`timescale 1ns/1ps
module tb_pool3_layer;

   localparam int NIN  = 1024;
   localparam int NOUT = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] blob_din;
   logic        blob_din_en;
   logic        blob_din_eop;
   logic        blob_din_rdy;
   logic [63:0] blob_dout;
   logic        blob_dout_en;
   logic        blob_dout_eop;
   logic        blob_dout_rdy;
   logic        pool_err;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] frm [2][NIN];
   logic [64:0] got_q [$];
   int          acc_cnt;
   int          first_acc;
   int          rdy_mode = 0;
   logic        rdy_force = 1'b0;

   pool3_layer dut (
      .clk           (clk),
      .rst           (rst),
      .blob_din      (blob_din),
      .blob_din_en   (blob_din_en),
      .blob_din_eop  (blob_din_eop),
      .blob_din_rdy  (blob_din_rdy),
      .blob_dout     (blob_dout),
      .blob_dout_en  (blob_dout_en),
      .blob_dout_eop (blob_dout_eop),
      .blob_dout_rdy (blob_dout_rdy),
      .pool_err      (pool_err)
   );

   always #5 clk = ~clk;

   // Output collector and accepted-input counter, sampled on the falling edge
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         got_q.delete();
         acc_cnt   = 0;
         first_acc = -1;
      end else begin
         if (blob_dout_en && first_acc < 0) first_acc = acc_cnt;
         if (blob_dout_en && blob_dout_rdy) got_q.push_back({blob_dout_eop, blob_dout});
         if (blob_din_en && blob_din_rdy) acc_cnt++;
      end
   end

   // Downstream ready: always, random, or under test control
   initial forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         0:       blob_dout_rdy = 1'b1;
         1:       blob_dout_rdy = ($urandom_range(0, 3) != 0);
         default: blob_dout_rdy = rdy_force;
      endcase
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1, "timeout");
   end

   // Reference: each output lane is the signed max over its 2x2 input window
   function automatic logic [64:0] exp_beat(input int f, input int o);
      int i, j, g, m, v;
      logic [63:0] r;
      i = o / 64;
      j = (o / 16) % 4;
      g = o % 16;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         m = -100000;
         for (int dh = 0; dh < 2; dh++)
            for (int dw = 0; dw < 2; dw++) begin
               v = int'($signed(frm[f][((2*i + dh) * 8 + 2*j + dw) * 16 + g][16*k +: 16]));
               if (v > m) m = v;
            end
         r[16*k +: 16] = 16'(m);
      end
      return {(o == NOUT - 1), r};
   endfunction

   task automatic gen_random(input int f);
      for (int b = 0; b < NIN; b++) frm[f][b] = {$urandom, $urandom};
   endtask

   task automatic do_reset();
      blob_din_en  = 1'b0;
      blob_din_eop = 1'b0;
      blob_din     = '0;
      rst          = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic send_beats(input int f, input int first, input int n, input int gap, input int eop_at);
      int t;
      for (int b = first; b < first + n; b++) begin
         while ($urandom_range(0, 99) < gap) begin
            blob_din_en = 1'b0;
            @(posedge clk);
            #1;
         end
         blob_din     = frm[f][b];
         blob_din_en  = 1'b1;
         blob_din_eop = (b == eop_at);
         t = 0;
         @(negedge clk);
         while (!blob_din_rdy && t < 500) begin
            @(negedge clk);
            t++;
         end
         if (!blob_din_rdy) begin
            checks++;
            errors++;
            $display("FAIL din_rdy_timeout beat %0d got 0 want 1", b);
         end
         @(posedge clk);
         #1;
      end
      blob_din_en  = 1'b0;
      blob_din_eop = 1'b0;
   endtask

   task automatic wait_out(input int n);
      for (int t = 0; t < 5000 && got_q.size() < n; t++) @(posedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      blob_din_en = 1'b0;
      blob_din_eop = 1'b0;
      blob_din = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (blob_dout_en !== 1'b0) begin errors++; $display("FAIL reset_dout_en got %b want 0", blob_dout_en); end
      checks++; if (blob_dout_eop !== 1'b0) begin errors++; $display("FAIL reset_dout_eop got %b want 0", blob_dout_eop); end
      checks++; if (blob_dout !== 64'h0) begin errors++; $display("FAIL reset_dout got %h want 0", blob_dout); end
      checks++; if (pool_err !== 1'b0) begin errors++; $display("FAIL reset_pool_err got %b want 0", pool_err); end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (blob_din_rdy !== 1'b1) begin errors++; $display("FAIL reset_din_rdy got %b want 1", blob_din_rdy); end
   endtask

   task automatic test_ramp();
      logic [64:0] e;
      int i, j, v;
      do_reset();
      rdy_mode = 0;
      for (int h = 0; h < 8; h++)
         for (int w = 0; w < 8; w++)
            for (int g = 0; g < 16; g++) frm[0][(h*8 + w)*16 + g] = {4{16'(h*8 + w)}};
      send_beats(0, 0, NIN, 0, NIN - 1);
      wait_out(NOUT);
      checks++; if (got_q.size() != NOUT) begin errors++; $display("FAIL ramp_count got %0d want %0d", got_q.size(), NOUT); end
      for (int o = 0; o < NOUT; o++) begin
         i = o / 64;
         j = (o / 16) % 4;
         v = (2*i + 1) * 8 + 2*j + 1;
         e = {(o == NOUT - 1), {4{16'(v)}}};
         checks++;
         if (o >= got_q.size() || got_q[o] !== e) begin
            errors++;
            $display("FAIL ramp_beat %0d got %h want %h", o, (o < got_q.size()) ? got_q[o] : 65'h0, e);
         end
      end
   endtask

   task automatic test_negative();
      logic [64:0] e;
      do_reset();
      gen_random(0);
      frm[0][0][15:0]   = 16'hFFFB;
      frm[0][16][15:0]  = 16'hFFFD;
      frm[0][128][15:0] = 16'h8000;
      frm[0][144][15:0] = 16'hFFFC;
      frm[0][32]  = 64'h8000_8000_8000_8000;
      frm[0][48]  = 64'h8000_8000_8000_8000;
      frm[0][160] = 64'h8000_8000_8000_8000;
      frm[0][176] = 64'h8000_8000_8000_8000;
      rdy_mode = 1;
      send_beats(0, 0, NIN, 30, NIN - 1);
      wait_out(NOUT);
      rdy_mode = 0;
      checks++; if (got_q.size() != NOUT) begin errors++; $display("FAIL neg_count got %0d want %0d", got_q.size(), NOUT); end
      if (got_q.size() == NOUT) begin
         checks++; if (got_q[0][15:0] !== 16'hFFFD) begin errors++; $display("FAIL neg_lane0 got %h want fffd", got_q[0][15:0]); end
         checks++; if (got_q[16][63:0] !== 64'h8000_8000_8000_8000) begin errors++; $display("FAIL neg_min got %h want 8000800080008000", got_q[16][63:0]); end
      end
      for (int o = 0; o < NOUT; o++) begin
         e = exp_beat(0, o);
         checks++;
         if (o >= got_q.size() || got_q[o] !== e) begin
            errors++;
            $display("FAIL neg_beat %0d got %h want %h", o, (o < got_q.size()) ? got_q[o] : 65'h0, e);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [64:0] e;
      do_reset();
      gen_random(0);
      rdy_force = 1'b0;
      rdy_mode  = 2;
      fork
         send_beats(0, 0, NIN, 0, NIN - 1);
         begin
            int t;
            logic [63:0] held;
            t = 0;
            @(negedge clk);
            while (!blob_dout_en && t < 3000) begin
               @(negedge clk);
               t++;
            end
            checks++; if (blob_dout_en !== 1'b1) begin errors++; $display("FAIL bp_first_out got %b want 1", blob_dout_en); end
            held = blob_dout;
            e = exp_beat(0, 0);
            checks++; if (held !== e[63:0]) begin errors++; $display("FAIL bp_first_data got %h want %h", held, e[63:0]); end
            for (int c = 0; c < 5; c++) begin
               if (c > 0) begin
                  @(negedge clk);
                  checks++; if (blob_dout !== held) begin errors++; $display("FAIL bp_hold cycle %0d got %h want %h", c, blob_dout, held); end
               end
               checks++; if (blob_din_rdy !== 1'b0) begin errors++; $display("FAIL bp_din_rdy cycle %0d got %b want 0", c, blob_din_rdy); end
            end
            rdy_force = 1'b1;
         end
      join
      wait_out(NOUT);
      rdy_mode = 0;
      checks++; if (got_q.size() != NOUT) begin errors++; $display("FAIL bp_count got %0d want %0d", got_q.size(), NOUT); end
      for (int o = 0; o < NOUT; o++) begin
         e = exp_beat(0, o);
         checks++;
         if (o >= got_q.size() || got_q[o] !== e) begin
            errors++;
            $display("FAIL bp_beat %0d got %h want %h", o, (o < got_q.size()) ? got_q[o] : 65'h0, e);
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [64:0] e;
      do_reset();
      rdy_mode = 0;
      gen_random(1);
      send_beats(1, 0, 300, 0, -1);
      #3 rst = 1'b0;
      #1;
      checks++; if (blob_dout_en !== 1'b0) begin errors++; $display("FAIL mid_rst_dout_en got %b want 0", blob_dout_en); end
      checks++; if (blob_dout !== 64'h0) begin errors++; $display("FAIL mid_rst_dout got %h want 0", blob_dout); end
      checks++; if (blob_din_rdy !== 1'b1) begin errors++; $display("FAIL mid_rst_din_rdy got %b want 1", blob_din_rdy); end
      @(posedge clk);
      #1 rst = 1'b1;
      gen_random(0);
      send_beats(0, 0, NIN, 20, NIN - 1);
      wait_out(NOUT);
      checks++; if (first_acc != 145) begin errors++; $display("FAIL mid_first_latency got %0d want 145", first_acc); end
      checks++; if (got_q.size() != NOUT) begin errors++; $display("FAIL mid_count got %0d want %0d", got_q.size(), NOUT); end
      for (int o = 0; o < NOUT; o++) begin
         e = exp_beat(0, o);
         checks++;
         if (o >= got_q.size() || got_q[o] !== e) begin
            errors++;
            $display("FAIL mid_beat %0d got %h want %h", o, (o < got_q.size()) ? got_q[o] : 65'h0, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [64:0] e;
      int neop;
      do_reset();
      rdy_mode = 0;
      gen_random(0);
      gen_random(1);
      send_beats(0, 0, NIN, 0, NIN - 1);
      send_beats(1, 0, NIN, 0, NIN - 1);
      wait_out(2 * NOUT);
      checks++; if (got_q.size() != 2 * NOUT) begin errors++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), 2 * NOUT); end
      neop = 0;
      foreach (got_q[q]) if (got_q[q][64]) neop++;
      checks++; if (neop != 2) begin errors++; $display("FAIL b2b_eop_count got %0d want 2", neop); end
      for (int o = 0; o < 2 * NOUT; o++) begin
         e = exp_beat(o / NOUT, o % NOUT);
         checks++;
         if (o >= got_q.size() || got_q[o] !== e) begin
            errors++;
            $display("FAIL b2b_beat %0d got %h want %h", o, (o < got_q.size()) ? got_q[o] : 65'h0, e);
         end
      end
   endtask

`ifdef POOL3_EOP_CHECK_EN
   task automatic test_eop_check();
      logic [64:0] e;
      int base;
      do_reset();
      rdy_mode = 0;
      gen_random(0);
      send_beats(0, 0, 500, 0, -1);
      checks++; if (pool_err !== 1'b0) begin errors++; $display("FAIL eop_err_before got %b want 0", pool_err); end
      send_beats(0, 500, 1, 0, 500);
      checks++; if (pool_err !== 1'b1) begin errors++; $display("FAIL eop_err_set got %b want 1", pool_err); end
      repeat (3) @(posedge clk);
      #1;
      base = got_q.size();
      gen_random(1);
      send_beats(1, 0, NIN, 0, NIN - 1);
      wait_out(base + NOUT);
      checks++; if (pool_err !== 1'b1) begin errors++; $display("FAIL eop_err_sticky got %b want 1", pool_err); end
      checks++; if (got_q.size() != base + NOUT) begin errors++; $display("FAIL eop_count got %0d want %0d", got_q.size() - base, NOUT); end
      for (int o = 0; o < NOUT; o++) begin
         e = exp_beat(1, o);
         checks++;
         if (base + o >= got_q.size() || got_q[base + o] !== e) begin
            errors++;
            $display("FAIL eop_beat %0d got %h want %h", o, (base + o < got_q.size()) ? got_q[base + o] : 65'h0, e);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_ramp();
      test_negative();
      test_backpressure();
      test_reset_midframe();
      test_back_to_back();
`ifdef POOL3_EOP_CHECK_EN
      test_eop_check();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pool3_layer.md
Name: pool3_layer

Overview:
- 2x2 stride-2 max-pooling stage directly downstream of the conv3 layer.
- Consumes the conv3 blob stream: 8x8x64 activations, 4 channels of 16 bits per 64-bit beat.
- Produces a 4x4x64 blob in the same beat format for the next layer.
- Handshake matches the blob_din/blob_dout convention used across the accelerator.

Parameters:
- W_IN, 8, input width; must be even.
- H_IN, 8, input height; must be even.
- C_IN, 64, input channels.
- KPF, 4, channels per beat.
- DW, 16, bits per channel value; signed two's complement, Q6.
- GRP, C_IN/KPF = 16, channel groups per pixel (localparam).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- blob_din  input  KPF*DW (64)  input beat; channel k occupies bits [16k+15:16k]
- blob_din_en  input  1  input beat valid
- blob_din_eop  input  1  marks the last beat of the input frame
- blob_din_rdy  output  1  stage can accept a beat this cycle
- blob_dout  output  64  pooled beat, same channel packing as blob_din
- blob_dout_en  output  1  output beat valid
- blob_dout_eop  output  1  marks the last output beat of the frame
- blob_dout_rdy  input  1  downstream can accept a beat
- pool_err  output  1  sticky framing error; tied to 0 unless POOL3_EOP_CHECK_EN

Behaviour:
- Input order: row h outermost, then column w, then channel group g fastest. One frame is W_IN*H_IN*GRP = 1024 beats.
- Output order: the same ordering over 4x4 pixels. One frame is 256 beats.
- Beat acceptance: a beat is accepted when blob_din_en && blob_din_rdy.
  - blob_din_rdy = !blob_dout_en || blob_dout_rdy (single output register, no skid).
- Counters: g (0..GRP-1), w (0..W_IN-1), h (0..H_IN-1). They advance only on an accepted beat and wrap to 0 after the last beat.
- Partial-max buffer: (W_IN/2)*GRP = 64 entries of 64 bits, implemented as a register array. Index is {w>>1, g}.
- Per accepted beat, applied lane-wise with a signed max over four 16-bit lanes:
  - h even, w even: buf[idx] <= din.
  - h even, w odd: buf[idx] <= max(buf[idx], din).
  - h odd, w even: buf[idx] <= max(buf[idx], din).
  - h odd, w odd: blob_dout <= max(buf[idx], din); blob_dout_en <= 1; the buffer is not written.
- Latency: 1 cycle from the accepted (h odd, w odd) beat to blob_dout_en = 1.
- blob_dout_en clears when blob_dout_rdy = 1 and no new output is produced in the same cycle.
- blob_dout_eop = 1 together with the output for h = H_IN-1, w = W_IN-1, g = GRP-1.
- Output hold: while blob_dout_en && !blob_dout_rdy, blob_dout and blob_dout_eop hold and no input is accepted.
- Output beat consumed and new input accepted in the same cycle: the new output replaces the old one and blob_dout_en stays 1.
- Reset (asynchronous, any time including mid-frame):
  - Counters are cleared to 0.
  - blob_dout_en = 0, blob_dout_eop = 0, blob_dout = 0, pool_err = 0.
  - Buffer contents are not reset; they are always written before they are read.
  - blob_din_rdy = 1 after reset.
- Equal values: max of -32768 and -32768 gives -32768. Signed compare only; no saturation is needed.

Optional Feature:
- Macro: POOL3_EOP_CHECK_EN.
- Defined:
  - An accepted blob_din_eop on any beat other than beat 1023 sets pool_err; it stays set until reset.
  - Counters resynchronize to 0 after that beat.
  - Reaching beat 1023 with blob_din_eop = 0 also sets pool_err; counters wrap normally.
- Undefined: blob_din_eop is ignored, framing is purely count-based, and pool_err is constant 0.

Decomposition:
- Package pool3_pkg:
  - DW, KPF and GRP constants.
  - lane typedef: logic signed [DW-1:0].
  - beat typedef: lane array [KPF].
  - Function max4 implementing the lane-wise signed max.
- Sub-module vec_max (combinational KPF-lane signed max) is natural and is reused for the buffer update and output paths.
- The counters and the handshake stay in pool3_layer.

Test Plan:
- Full frame, blob_dout_rdy = 1, input lane value = h*8+w for every lane → 256 output beats; output pixel (i,j) equals (2i+1)*8+2j+1; eop on beat 255 only.
- Negative values: window {-5, -3, -32768, -4} in lane 0 → output lane 0 = -3. Window of all -32768 → -32768.
- Backpressure: hold blob_dout_rdy = 0 for 5 cycles at the first output → blob_din_rdy = 0 and blob_dout stable across those cycles; the frame result matches the no-stall run.
- Reset asserted after 300 beats, then a full fresh frame → all outputs are correct and the first output appears after accepted beat 145 (h=1, w=1, g=0).
- Two back-to-back frames with input valid every cycle → 512 outputs, exactly two eop pulses, no lost or duplicated beats.
- With POOL3_EOP_CHECK_EN, eop asserted on beat 500 → pool_err = 1 next cycle; a following well-formed frame produces correct data and pool_err stays 1.
